// File: rtl/axi_mst_read_ot_if.sv
// AXI4 read channels (AR, R) plus the AXIS output stream of the read engine.
// The master modport is the engine side; slave is the memory and stream-sink side.
interface axi_mst_read_ot_if #(
   parameter int ID_WIDTH       = 6,
   parameter int DATA_WIDTH     = 64,
   parameter int B_BURST_LENGTH = 8
);
   logic [ID_WIDTH-1:0]       m_axi_arid;
   logic [31:0]               m_axi_araddr;
   logic [B_BURST_LENGTH-1:0] m_axi_arlen;
   logic [2:0]                m_axi_arsize;
   logic [1:0]                m_axi_arburst;
   logic [1:0]                m_axi_arlock;
   logic [3:0]                m_axi_arcache;
   logic [2:0]                m_axi_arprot;
   logic [3:0]                m_axi_arqos;
   logic                      m_axi_arvalid;
   logic                      m_axi_arready;
   logic [ID_WIDTH-1:0]       m_axi_rid;
   logic [DATA_WIDTH-1:0]     m_axi_rdata;
   logic [1:0]                m_axi_rresp;
   logic                      m_axi_rlast;
   logic                      m_axi_rvalid;
   logic                      m_axi_rready;
   logic                      m_axis_tvalid;
   logic [DATA_WIDTH-1:0]     m_axis_tdata;
   logic [DATA_WIDTH/8-1:0]   m_axis_tstrb;
   logic                      m_axis_tlast;
   logic                      m_axis_tready;

   modport master (
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
             m_axi_rready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast,
      input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid, m_axis_tready
   );

   modport slave (
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
             m_axi_rready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast,
      output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid, m_axis_tready
   );
endinterface

// File: rtl/axi_mst_read_ot.sv
// AXI4 read master for DDR bandwidth measurement: issues NBURST INCR bursts with up to
// MAX_OT outstanding, streams R data straight to AXIS, reports cycle count and errors.
//
// state | meaning
// IDLE  | waiting for a start edge with a valid configuration
// RUN   | issuing AR bursts and forwarding R beats until the last burst's rlast
module axi_mst_read_ot #(
   parameter int ID_WIDTH       = 6,
   parameter int DATA_WIDTH     = 64,
   parameter int B_BURST_LENGTH = 8,
   parameter int MAX_OT         = 4
) (
   input  logic                      m_axi_aclk,
   input  logic                      m_axi_aresetn,
   axi_mst_read_ot_if.master         bus,
   input  logic                      START_REG,
   input  logic [31:0]               ADDR_REG,
   input  logic [31:0]               NBURST_REG,
   input  logic [B_BURST_LENGTH-1:0] BLEN_REG,
   output logic                      IDLE_REG,
   output logic [31:0]               CYCLES_REG,
   output logic [2:0]                ERR_REG
);
   localparam int unsigned SIZE = $clog2(DATA_WIDTH/8);
   localparam int          OT_W = $clog2(MAX_OT + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                    state_q, state_d;
   logic                      start_q, start_qq;
   logic [31:0]               addr_q, addr_d;
   logic [31:0]               nburst_q, nburst_d;
   logic [B_BURST_LENGTH-1:0] blen_q, blen_d;
   logic [31:0]               bytes_q, bytes_d;
   logic [31:0]               issued_q, issued_d;
   logic [31:0]               done_q, done_d;
   logic [OT_W-1:0]           ot_q, ot_d;
   logic [B_BURST_LENGTH-1:0] beat_q, beat_d;
   logic [31:0]               cycles_q, cycles_d;
   logic [2:0]                err_q, err_d;
   logic                      arvalid_q, arvalid_d;

   logic        start_pulse, run, ar_hs, r_hs, last_burst, cfg_ok;
   logic [31:0] cfg_bytes;

   assign start_pulse = start_q & ~start_qq;
   assign run         = (state_q == RUN);
   assign ar_hs       = arvalid_q & bus.m_axi_arready;
   assign r_hs        = bus.m_axi_rvalid & bus.m_axi_rready;
   assign last_burst  = (done_q == nburst_q - 32'd1);
   assign cfg_bytes   = (32'(BLEN_REG) + 32'd1) << SIZE;
   // Bursts must not cross a 4 KB boundary, so size and alignment are both required.
   assign cfg_ok      = (cfg_bytes <= 32'd4096) && ((ADDR_REG % cfg_bytes) == 32'd0);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      nburst_d = nburst_q;
      blen_d   = blen_q;
      bytes_d  = bytes_q;
      issued_d = issued_q;
      done_d   = done_q;
      ot_d     = ot_q;
      beat_d   = beat_q;
      cycles_d = cycles_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start_pulse && NBURST_REG != 32'd0) begin
               if (cfg_ok) begin
                  state_d  = RUN;
                  addr_d   = ADDR_REG;
                  nburst_d = NBURST_REG;
                  blen_d   = BLEN_REG;
                  bytes_d  = cfg_bytes;
                  issued_d = '0;
                  done_d   = '0;
                  ot_d     = '0;
                  beat_d   = '0;
                  cycles_d = '0;
                  err_d    = '0;
               end else begin
                  err_d = 3'b010;
               end
            end
         end
         RUN: begin
            cycles_d = cycles_q + 32'd1;
            if (ar_hs) begin
               addr_d   = addr_q + bytes_q;
               issued_d = issued_q + 32'd1;
            end
            if (ar_hs && !(r_hs && bus.m_axi_rlast)) begin
               ot_d = ot_q + OT_W'(1);
            end else if (!ar_hs && r_hs && bus.m_axi_rlast && ot_q != '0) begin
               ot_d = ot_q - OT_W'(1);
            end
            if (r_hs) begin
               if (bus.m_axi_rresp != 2'b00) err_d[0] = 1'b1;
               if (bus.m_axi_rlast != (beat_q == blen_q)) err_d[2] = 1'b1;
               if (bus.m_axi_rlast) begin
                  beat_d = '0;
                  done_d = done_q + 32'd1;
                  if (last_burst) state_d = IDLE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Computed from next-cycle counters so a new AR can follow a handshake directly.
      arvalid_d = (state_d == RUN) && (issued_d < nburst_d) && (ot_d < OT_W'(MAX_OT));
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q   <= IDLE;
         start_q   <= 1'b0;
         start_qq  <= 1'b0;
         addr_q    <= '0;
         nburst_q  <= '0;
         blen_q    <= '0;
         bytes_q   <= '0;
         issued_q  <= '0;
         done_q    <= '0;
         ot_q      <= '0;
         beat_q    <= '0;
         cycles_q  <= '0;
         err_q     <= '0;
         arvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= START_REG;
         start_qq  <= start_q;
         addr_q    <= addr_d;
         nburst_q  <= nburst_d;
         blen_q    <= blen_d;
         bytes_q   <= bytes_d;
         issued_q  <= issued_d;
         done_q    <= done_d;
         ot_q      <= ot_d;
         beat_q    <= beat_d;
         cycles_q  <= cycles_d;
         err_q     <= err_d;
         arvalid_q <= arvalid_d;
      end
   end

   assign bus.m_axi_arid    = '0;
   assign bus.m_axi_araddr  = addr_q;
   assign bus.m_axi_arlen   = blen_q;
   assign bus.m_axi_arsize  = 3'(SIZE);
   assign bus.m_axi_arburst = 2'b01;
   assign bus.m_axi_arlock  = 2'b00;
   assign bus.m_axi_arcache = 4'b0011;
   assign bus.m_axi_arprot  = 3'b000;
   assign bus.m_axi_arqos   = 4'b0000;
   assign bus.m_axi_arvalid = arvalid_q;

   assign bus.m_axi_rready  = bus.m_axis_tready & run;
   assign bus.m_axis_tvalid = bus.m_axi_rvalid & run;
   assign bus.m_axis_tdata  = bus.m_axi_rdata;
   assign bus.m_axis_tstrb  = '1;
   assign bus.m_axis_tlast  = bus.m_axi_rlast & last_burst;

   assign IDLE_REG   = (state_q == IDLE);
   assign CYCLES_REG = cycles_q;
   assign ERR_REG    = err_q;
endmodule

// File: tb/tb_axi_mst_read_ot.sv
// Bench for axi_mst_read_ot: a table of transfer configurations against a small AXI
// read slave model with incrementing data, plus a reset-during-transfer sequence.
module tb_axi_mst_read_ot;
   localparam int ID_WIDTH = 6;
   localparam int DW       = 64;
   localparam int BBL      = 8;
   localparam int MAX_OT   = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            START_REG = 1'b0;
   logic [31:0]     ADDR_REG = '0;
   logic [31:0]     NBURST_REG = '0;
   logic [BBL-1:0]  BLEN_REG = '0;
   logic            IDLE_REG;
   logic [31:0]     CYCLES_REG;
   logic [2:0]      ERR_REG;

   axi_mst_read_ot_if #(.ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DW), .B_BURST_LENGTH(BBL)) bus ();

   axi_mst_read_ot #(.ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DW), .B_BURST_LENGTH(BBL), .MAX_OT(MAX_OT)) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .bus(bus),
      .START_REG(START_REG), .ADDR_REG(ADDR_REG), .NBURST_REG(NBURST_REG), .BLEN_REG(BLEN_REG),
      .IDLE_REG(IDLE_REG), .CYCLES_REG(CYCLES_REG), .ERR_REG(ERR_REG)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] nburst;
      logic [7:0]  blen;
      int          tmode;
      int          r_delay;
      int          err_burst;
      int          err_beat;
      int          early_burst;
      int          exp_ars;
      int          exp_beats;
      int          exp_ot_first;
      int          exp_cycles;
      logic [2:0]  exp_err;
   } vec_t;

   vec_t vecs[9];

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int n_ar, n_beats, n_done, ot, max_ot, ar_first, beat, ar_err, beat_err, rr_err, ar_limit;
   int tmode, r_delay, err_burst, err_beat, early_burst;
   bit active;
   logic [31:0] cur_addr, cur_nburst, cur_bytes;
   logic [7:0]  cur_blen;
   logic [63:0] slave_data;
   int q_len[$], q_rdy[$], q_idx[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic check_ge(input string name, input logic [63:0] act, input logic [63:0] min);
      n_chk++;
      if (act < min) $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
      else n_pass++;
   endtask

   task automatic model_reset(input vec_t v);
      n_ar = 0; n_beats = 0; n_done = 0; ot = 0; max_ot = 0; ar_first = -1; beat = 0;
      ar_err = 0; beat_err = 0; rr_err = 0; ar_limit = 1 << 30; active = 1'b0;
      tmode = v.tmode; r_delay = v.r_delay; err_burst = v.err_burst;
      err_beat = v.err_beat; early_burst = v.early_burst;
      cur_addr = v.addr; cur_nburst = v.nburst; cur_blen = v.blen;
      cur_bytes = (32'(v.blen) + 32'd1) * 32'd8;
      slave_data = 64'h0000_0100;
      q_len.delete(); q_rdy.delete(); q_idx.delete();
   endtask

   // One clock of the slave: drive inputs at negedge, sample 1 ns later, update the model.
   task automatic slave_cycle();
      logic [31:0] exp_addr;
      @(negedge clk);
      cyc++;
      bus.m_axi_arready = (n_ar < ar_limit);
      bus.m_axis_tready = (tmode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (q_len.size() > 0 && cyc >= q_rdy[0]) begin
         bus.m_axi_rvalid = 1'b1;
         bus.m_axi_rdata  = slave_data;
         bus.m_axi_rlast  = (beat == q_len[0]) || (q_idx[0] == early_burst && beat == q_len[0] - 1);
         bus.m_axi_rresp  = (q_idx[0] == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
         bus.m_axi_rvalid = 1'b0;
         bus.m_axi_rlast  = 1'b0;
         bus.m_axi_rresp  = 2'b00;
      end
      #1;
      if (active && (bus.m_axi_rready !== bus.m_axis_tready || bus.m_axis_tvalid !== bus.m_axi_rvalid))
         rr_err++;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
         exp_addr = cur_addr + 32'(n_ar) * cur_bytes;
         if (bus.m_axi_araddr !== exp_addr || bus.m_axi_arlen !== cur_blen) ar_err++;
         q_len.push_back(int'(bus.m_axi_arlen));
         q_rdy.push_back(cyc + 1 + r_delay);
         q_idx.push_back(n_ar);
         n_ar++;
         ot++;
         if (ot > max_ot) max_ot = ot;
         active = 1'b1;
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
         if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== slave_data ||
             bus.m_axis_tlast !== (bus.m_axi_rlast && q_idx[0] == int'(cur_nburst) - 1))
            beat_err++;
         slave_data++;
         n_beats++;
         if (bus.m_axi_rlast) begin
            if (n_done == 0) ar_first = n_ar;
            void'(q_len.pop_front()); void'(q_rdy.pop_front()); void'(q_idx.pop_front());
            beat = 0;
            n_done++;
            ot--;
            if (n_done == int'(cur_nburst)) active = 1'b0;
         end else begin
            beat++;
         end
      end
   endtask

   task automatic run_vector(input vec_t v, input int idx);
      bit timeout;
      model_reset(v);
      ADDR_REG = v.addr; NBURST_REG = v.nburst; BLEN_REG = v.blen;
      START_REG = 1'b1;
      timeout = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         slave_cycle();
         if (i == 4) START_REG = 1'b0;
         if (v.exp_ars == 0 && i >= 12) begin timeout = 1'b0; break; end
         if (v.exp_ars > 0 && n_done == v.exp_ars && IDLE_REG) begin timeout = 1'b0; break; end
      end
      START_REG = 1'b0;
      check($sformatf("v%0d_timeout", idx), 64'(timeout), 64'd0);
      check($sformatf("v%0d_ar_count", idx), 64'(n_ar), 64'(v.exp_ars));
      check($sformatf("v%0d_beats", idx), 64'(n_beats), 64'(v.exp_beats));
      check($sformatf("v%0d_err_reg", idx), 64'(ERR_REG), 64'(v.exp_err));
      check($sformatf("v%0d_idle_reg", idx), 64'(IDLE_REG), 64'd1);
      check($sformatf("v%0d_ar_payload", idx), 64'(ar_err), 64'd0);
      check($sformatf("v%0d_beat_data_last", idx), 64'(beat_err), 64'd0);
      check($sformatf("v%0d_rready_mirror", idx), 64'(rr_err), 64'd0);
      if (v.exp_ars > 0) begin
         check_ge($sformatf("v%0d_cycles_min", idx), 64'(CYCLES_REG), 64'(v.exp_beats));
         check($sformatf("v%0d_ot_bound", idx), 64'(max_ot > MAX_OT), 64'd0);
      end
      if (v.exp_ot_first >= 0)
         check($sformatf("v%0d_ar_before_rlast", idx), 64'(ar_first), 64'(v.exp_ot_first));
      if (v.exp_cycles >= 0)
         check($sformatf("v%0d_cycles_exact", idx), 64'(CYCLES_REG), 64'(v.exp_cycles));
   endtask

   initial begin
      //            addr        nburst  blen  tm dly eb ebt early ars beats otf cyc  err
      vecs[0] = '{32'h1000, 32'd4, 8'd15,  0, 0,  -1, -1, -1,   4,  64,  -1, 65, 3'b000};
      vecs[1] = '{32'h0000, 32'd0, 8'd15,  0, 0,  -1, -1, -1,   0,   0,  -1, -1, 3'b000};
      vecs[2] = '{32'h0000, 32'd8, 8'd3,   0, 50, -1, -1, -1,   8,  32,   4, -1, 3'b000};
      vecs[3] = '{32'h1040, 32'd4, 8'd15,  0, 0,  -1, -1, -1,   0,   0,  -1, -1, 3'b010};
      vecs[4] = '{32'h2000, 32'd3, 8'd7,   1, 2,  -1, -1, -1,   3,  24,  -1, -1, 3'b000};
      vecs[5] = '{32'h0800, 32'd1, 8'd255, 0, 0,  -1, -1, -1,   1, 256,  -1, -1, 3'b000};
      vecs[6] = '{32'h0030, 32'd2, 8'd2,   0, 1,  -1, -1, -1,   2,   6,  -1, -1, 3'b000};
      vecs[7] = '{32'h0020, 32'd2, 8'd2,   0, 0,  -1, -1, -1,   0,   0,  -1, -1, 3'b010};
      vecs[8] = '{32'h0000, 32'd4, 8'd7,   0, 3,   2,  3,  3,   4,  31,  -1, -1, 3'b101};

      bus.m_axi_arready = 1'b0;
      bus.m_axi_rid     = '0;
      bus.m_axi_rdata   = '0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rlast   = 1'b0;
      bus.m_axi_rvalid  = 1'b1;
      bus.m_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_idle", 64'(IDLE_REG), 64'd1);
      check("rst_cycles", 64'(CYCLES_REG), 64'd0);
      check("rst_err", 64'(ERR_REG), 64'd0);
      check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
      check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("rst_rready", 64'(bus.m_axi_rready), 64'd0);
      check("const_arsize", 64'(bus.m_axi_arsize), 64'd3);
      check("const_arburst", 64'(bus.m_axi_arburst), 64'd1);
      check("const_arcache", 64'(bus.m_axi_arcache), 64'd3);
      check("const_tstrb", 64'(bus.m_axis_tstrb), 64'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      bus.m_axi_rvalid = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) run_vector(vecs[i], i);

      // Reset while two bursts are outstanding and the slave stalls further ARs.
      model_reset(vecs[0]);
      ADDR_REG = 32'h0; NBURST_REG = 32'd4; BLEN_REG = 8'd7;
      cur_addr = 32'h0; cur_nburst = 32'd4; cur_blen = 8'd7; cur_bytes = 32'd64;
      r_delay = 1000; ar_limit = 2;
      START_REG = 1'b1;
      for (int i = 0; i < 60; i++) begin
         slave_cycle();
         if (i == 4) START_REG = 1'b0;
         if (i >= 6 && n_ar == 2) break;
      end
      START_REG = 1'b0;
      bus.m_axi_rvalid = 1'b1;
      bus.m_axis_tready = 1'b1;
      #1;
      check("mid_ar_count", 64'(n_ar), 64'd2);
      check("mid_arvalid_before", 64'(bus.m_axi_arvalid), 64'd1);
      check("mid_idle_before", 64'(IDLE_REG), 64'd0);
      check("mid_tvalid_before", 64'(bus.m_axis_tvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_arvalid_rst", 64'(bus.m_axi_arvalid), 64'd0);
      check("mid_tvalid_rst", 64'(bus.m_axis_tvalid), 64'd0);
      check("mid_rready_rst", 64'(bus.m_axi_rready), 64'd0);
      check("mid_idle_rst", 64'(IDLE_REG), 64'd1);
      bus.m_axi_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_vector(vecs[0], 9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
